// File: rtl/tlb_responder.sv
// -----------------------------------------------------------------------------
// tlb_responder
//
// Joint TLB for the mapped segments (kuseg, kseg2, kseg3). It holds ENTRIES
// dual-page entries with 4 KB pages and serves three operations:
//   - registered lookups with one-cycle latency
//   - indexed and random writes (TLBWI / TLBWR)
//   - probes (TLBP)
// It also keeps the Random index counter that TLBWR uses.
//
// Optional feature (compile-time macro TLB_STATS_EN):
//   defined   -> 32-bit lookup hit/miss counters are built
//   undefined -> hit_count / miss_count are tied to zero
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               lookup request (valid/ready, vaddr, asid, store)
//   resp_*              lookup response, one-cycle valid pulse
//   tlbw_*              entry write (indexed or at random_o)
//   entryhi_i           VPN2 [31:13], ASID [7:0] for writes and probes
//   entrylo0_i/1_i      even/odd page: PFN [25:6], C [5:3], D [2], V [1], G [0]
//   tlbp_en             probe request using entryhi_i
//   probe_valid/result  probe response; bit31 = not found, low bits = index
//   wired_i             CP0 Wired value (lower bound of Random)
//   random_o            current Random index
//   hit_count/miss_count lookup statistics
// -----------------------------------------------------------------------------
module tlb_responder #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_vaddr,
   input  logic [7:0]       req_asid,
   input  logic             req_store,
   output logic             resp_valid,
   output logic [31:0]      resp_paddr,
   output logic             resp_miss,
   output logic             resp_invalid,
   output logic             resp_modified,
   output logic             resp_uncached,
   input  logic             tlbw_en,
   input  logic             tlbw_random,
   input  logic [IDX_W-1:0] tlbw_index,
   input  logic [31:0]      entryhi_i,
   input  logic [31:0]      entrylo0_i,
   input  logic [31:0]      entrylo1_i,
   input  logic             tlbp_en,
   output logic             probe_valid,
   output logic [31:0]      probe_result,
   input  logic [IDX_W-1:0] wired_i,
   output logic [IDX_W-1:0] random_o,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
);

   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRIES - 1);

   // Entry storage
   logic [18:0] e_vpn2 [ENTRIES];
   logic [7:0]  e_asid [ENTRIES];
   logic        e_g    [ENTRIES];
   logic [19:0] e_pfn0 [ENTRIES];
   logic [19:0] e_pfn1 [ENTRIES];
   logic [2:0]  e_c0   [ENTRIES];
   logic [2:0]  e_c1   [ENTRIES];
   logic        e_d0   [ENTRIES];
   logic        e_d1   [ENTRIES];
   logic        e_v0   [ENTRIES];
   logic        e_v1   [ENTRIES];

   logic             accept;
   logic [IDX_W-1:0] wr_idx;

   logic             lk_hit;
   logic [IDX_W-1:0] lk_idx;
   logic [19:0]      sel_pfn;
   logic [2:0]       sel_c;
   logic             sel_d;
   logic             sel_v;
   logic [31:0]      lk_paddr;
   logic             lk_miss;
   logic             lk_invalid;
   logic             lk_modified;
   logic             lk_uncached;

   logic             pr_hit;
   logic [IDX_W-1:0] pr_idx;
   logic [31:0]      pr_result;

   logic [IDX_W-1:0] random_next;

   // Fields of the entry words that the TLB does not store.
   logic unused_bits;
   assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

   // Entry match: same VPN2 and either global or same ASID.
   function automatic logic entry_match(
      input logic [18:0] ent_vpn2,
      input logic [7:0]  ent_asid,
      input logic        ent_g,
      input logic [18:0] vpn2,
      input logic [7:0]  asid
   );
      return (ent_vpn2 == vpn2) && (ent_g || (ent_asid == asid));
   endfunction

   // Lookups stall while a write occupies the array.
   assign req_ready = ~rst & ~tlbw_en;
   assign accept    = req_valid & ~tlbw_en;

   // TLBWR uses the Random value present in the same cycle as the write.
   assign wr_idx = tlbw_random ? random_o : tlbw_index;

   // Entry array: reset clears valid and global bits, write updates one entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            e_vpn2[i] <= 19'h0;
            e_asid[i] <= 8'h0;
            e_g[i]    <= 1'b0;
            e_pfn0[i] <= 20'h0;
            e_pfn1[i] <= 20'h0;
            e_c0[i]   <= 3'h0;
            e_c1[i]   <= 3'h0;
            e_d0[i]   <= 1'b0;
            e_d1[i]   <= 1'b0;
            e_v0[i]   <= 1'b0;
            e_v1[i]   <= 1'b0;
         end
      end else if (tlbw_en) begin
         e_vpn2[wr_idx] <= entryhi_i[31:13];
         e_asid[wr_idx] <= entryhi_i[7:0];
         e_g[wr_idx]    <= entrylo0_i[0] & entrylo1_i[0];
         e_pfn0[wr_idx] <= entrylo0_i[25:6];
         e_pfn1[wr_idx] <= entrylo1_i[25:6];
         e_c0[wr_idx]   <= entrylo0_i[5:3];
         e_c1[wr_idx]   <= entrylo1_i[5:3];
         e_d0[wr_idx]   <= entrylo0_i[2];
         e_d1[wr_idx]   <= entrylo1_i[2];
         e_v0[wr_idx]   <= entrylo0_i[1];
         e_v1[wr_idx]   <= entrylo1_i[1];
      end
   end

   // Lookup search; scanning downwards lets the lowest matching index win.
   always_comb begin
      lk_hit = 1'b0;
      lk_idx = {IDX_W{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         lk_idx = entry_match(e_vpn2[i], e_asid[i], e_g[i], req_vaddr[31:13], req_asid)
                  ? IDX_W'(i) : lk_idx;
         lk_hit = lk_hit |
                  entry_match(e_vpn2[i], e_asid[i], e_g[i], req_vaddr[31:13], req_asid);
      end
   end

   // Page select: vaddr bit 12 picks the odd page of the pair.
   always_comb begin
      sel_pfn = 20'h0;
      sel_c   = 3'h0;
      sel_d   = 1'b0;
      sel_v   = 1'b0;
      if (req_vaddr[12]) begin
         sel_pfn = e_pfn1[lk_idx];
         sel_c   = e_c1[lk_idx];
         sel_d   = e_d1[lk_idx];
         sel_v   = e_v1[lk_idx];
      end else begin
         sel_pfn = e_pfn0[lk_idx];
         sel_c   = e_c0[lk_idx];
         sel_d   = e_d0[lk_idx];
         sel_v   = e_v0[lk_idx];
      end
   end

   // Result flags with priority miss > invalid > modified; uncached only when clean.
   always_comb begin
      lk_paddr    = 32'h0;
      lk_miss     = 1'b0;
      lk_invalid  = 1'b0;
      lk_modified = 1'b0;
      lk_uncached = 1'b0;
      if (!lk_hit) begin
         lk_miss = 1'b1;
      end else begin
         lk_paddr = {sel_pfn, req_vaddr[11:0]};
         if (!sel_v) begin
            lk_invalid = 1'b1;
         end else if (req_store && !sel_d) begin
            lk_modified = 1'b1;
         end else begin
            lk_uncached = (sel_c == 3'b010);
         end
      end
   end

   // Response register; a reset between accept and response drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid    <= 1'b0;
         resp_paddr    <= 32'h0;
         resp_miss     <= 1'b0;
         resp_invalid  <= 1'b0;
         resp_modified <= 1'b0;
         resp_uncached <= 1'b0;
      end else begin
         resp_valid <= accept;
         if (accept) begin
            resp_paddr    <= lk_paddr;
            resp_miss     <= lk_miss;
            resp_invalid  <= lk_invalid;
            resp_modified <= lk_modified;
            resp_uncached <= lk_uncached;
         end
      end
   end

   // Probe search on the current contents, i.e. before a same-cycle write.
   always_comb begin
      pr_hit = 1'b0;
      pr_idx = {IDX_W{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         pr_idx = entry_match(e_vpn2[i], e_asid[i], e_g[i], entryhi_i[31:13], entryhi_i[7:0])
                  ? IDX_W'(i) : pr_idx;
         pr_hit = pr_hit |
                  entry_match(e_vpn2[i], e_asid[i], e_g[i], entryhi_i[31:13], entryhi_i[7:0]);
      end
   end

   // Probe result word: not-found flag in bit 31, index in the low bits.
   always_comb begin
      pr_result = 32'h0;
      if (pr_hit) begin
         pr_result = {{(32 - IDX_W){1'b0}}, pr_idx};
      end else begin
         pr_result = 32'h8000_0000;
      end
   end

   // Probe response register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         probe_valid  <= 1'b0;
         probe_result <= 32'h0;
      end else begin
         probe_valid <= tlbp_en;
         if (tlbp_en) begin
            probe_result <= pr_result;
         end
      end
   end

   // Random wraps to the top once it reaches Wired, or if Wired lies above it.
   always_comb begin
      random_next = TOP_IDX;
      if (wired_i >= random_o) begin
         random_next = TOP_IDX;
      end else begin
         random_next = random_o - {{(IDX_W - 1){1'b0}}, 1'b1};
      end
   end

   // Random counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         random_o <= TOP_IDX;
      end else begin
         random_o <= random_next;
      end
   end

`ifdef TLB_STATS_EN
   // Lookup statistics, counted when the response is produced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else if (accept) begin
         if (lk_miss) begin
            miss_count <= miss_count + 32'h1;
         end else begin
            hit_count <= hit_count + 32'h1;
         end
      end
   end
`else
   assign hit_count  = 32'h0;
   assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_tlb_responder.sv
module tb_tlb_responder;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;
`ifdef TLB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [31:0]      req_vaddr = 32'h0;
   logic [7:0]       req_asid = 8'h0;
   logic             req_store = 1'b0;
   logic             resp_valid;
   logic [31:0]      resp_paddr;
   logic             resp_miss, resp_invalid, resp_modified, resp_uncached;
   logic             tlbw_en = 1'b0;
   logic             tlbw_random = 1'b0;
   logic [IDX_W-1:0] tlbw_index = 4'h0;
   logic [31:0]      entryhi_i = 32'h0;
   logic [31:0]      entrylo0_i = 32'h0;
   logic [31:0]      entrylo1_i = 32'h0;
   logic             tlbp_en = 1'b0;
   logic             probe_valid;
   logic [31:0]      probe_result;
   logic [IDX_W-1:0] wired_i = 4'h0;
   logic [IDX_W-1:0] random_o;
   logic [31:0]      hit_count, miss_count;

   always #5 clk = ~clk;

   tlb_responder #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
      .req_asid(req_asid), .req_store(req_store),
      .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_miss(resp_miss),
      .resp_invalid(resp_invalid), .resp_modified(resp_modified),
      .resp_uncached(resp_uncached),
      .tlbw_en(tlbw_en), .tlbw_random(tlbw_random), .tlbw_index(tlbw_index),
      .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
      .tlbp_en(tlbp_en), .probe_valid(probe_valid), .probe_result(probe_result),
      .wired_i(wired_i), .random_o(random_o),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: raw entry words as written, decoded only at lookup time.
   logic [18:0] m_vpn2 [ENTRIES];
   logic [7:0]  m_asid [ENTRIES];
   logic        m_g    [ENTRIES];
   logic [31:0] m_lo0  [ENTRIES];
   logic [31:0] m_lo1  [ENTRIES];
   int          m_rand;
   int          m_hit;
   int          m_miss;

   typedef struct {
      logic [31:0] va;
      logic [7:0]  asid;
      logic        store;
      logic [31:0] pa;
      logic        miss, inv, modf, unc;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < ENTRIES; i++) begin
         m_vpn2[i] = 19'h0; m_asid[i] = 8'h0; m_g[i] = 1'b0;
         m_lo0[i] = 32'h0;  m_lo1[i] = 32'h0;
      end
      m_rand = ENTRIES - 1;
      m_hit  = 0;
      m_miss = 0;
   endtask

   function automatic int model_find(input logic [18:0] vpn2, input logic [7:0] asid);
      for (int i = 0; i < ENTRIES; i++)
         if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) return i;
      return -1;
   endfunction

   task automatic model_lookup(input logic [31:0] va, input logic [7:0] asid, input logic store,
                               output logic [31:0] pa, output logic miss, output logic inv,
                               output logic modf, output logic unc);
      int          k;
      logic [31:0] lo;
      pa = 32'h0; miss = 1'b1; inv = 1'b0; modf = 1'b0; unc = 1'b0;
      k = model_find(va[31:13], asid);
      if (k >= 0) begin
         lo   = va[12] ? m_lo1[k] : m_lo0[k];
         miss = 1'b0;
         pa   = {lo[25:6], va[11:0]};
         if (!lo[1])              inv  = 1'b1;
         else if (store && !lo[2]) modf = 1'b1;
         else                      unc  = (lo[5:3] == 3'd2);
      end
   endtask

   // One clock: predict from current inputs, advance model, compare after the edge.
   task automatic tick();
      logic [31:0] e_pa, e_pr;
      logic        e_miss, e_inv, e_mod, e_unc, e_rv, e_pv;
      int          w, k;
      e_rv = req_valid && !tlbw_en;
      e_pa = 32'h0; e_miss = 1'b0; e_inv = 1'b0; e_mod = 1'b0; e_unc = 1'b0; e_pr = 32'h0;
      if (e_rv) model_lookup(req_vaddr, req_asid, req_store, e_pa, e_miss, e_inv, e_mod, e_unc);
      e_pv = tlbp_en;
      if (e_pv) begin
         k    = model_find(entryhi_i[31:13], entryhi_i[7:0]);
         e_pr = (k < 0) ? 32'h8000_0000 : k;
      end
      if (tlbw_en) begin
         w = tlbw_random ? m_rand : int'(tlbw_index);
         m_vpn2[w] = entryhi_i[31:13]; m_asid[w] = entryhi_i[7:0];
         m_g[w] = entrylo0_i[0] & entrylo1_i[0];
         m_lo0[w] = entrylo0_i; m_lo1[w] = entrylo1_i;
      end
      if (e_rv) begin
         if (e_miss) m_miss++; else m_hit++;
      end
      m_rand = (int'(wired_i) >= m_rand) ? ENTRIES - 1 : m_rand - 1;
      #1;
      chk("req_ready", req_ready, !tlbw_en);
      @(posedge clk);
      #1;
      chk("resp_valid", resp_valid, e_rv);
      if (e_rv) begin
         chk("resp_paddr", resp_paddr, e_pa);
         chk("resp_flags", {resp_miss, resp_invalid, resp_modified, resp_uncached},
             {e_miss, e_inv, e_mod, e_unc});
      end
      chk("probe_valid", probe_valid, e_pv);
      if (e_pv) chk("probe_result", probe_result, e_pr);
      chk("random_o", random_o, m_rand);
      chk("hit_count", hit_count, STATS ? m_hit : 0);
      chk("miss_count", miss_count, STATS ? m_miss : 0);
   endtask

   task automatic idle();
      req_valid = 1'b0; req_store = 1'b0; tlbw_en = 1'b0; tlbw_random = 1'b0; tlbp_en = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic do_write(input logic [3:0] idx, input logic rnd, input logic [31:0] hi,
                           input logic [31:0] lo0, input logic [31:0] lo1);
      tlbw_en = 1'b1; tlbw_random = rnd; tlbw_index = idx;
      entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
      tick();
      tlbw_en = 1'b0; tlbw_random = 1'b0;
   endtask

   task automatic do_lookup(input logic [31:0] va, input logic [7:0] asid, input logic st);
      req_valid = 1'b1; req_vaddr = va; req_asid = asid; req_store = st;
      tick();
      req_valid = 1'b0; req_store = 1'b0;
   endtask

   task automatic do_probe(input logic [31:0] hi);
      tlbp_en = 1'b1; entryhi_i = hi;
      tick();
      tlbp_en = 1'b0;
   endtask

   initial begin
      vt[0] = '{32'h0040_0ABC, 8'd5, 1'b0, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{32'h0040_0ABC, 8'd6, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{32'h0040_1000, 8'd5, 1'b0, 32'h00AB_C000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3] = '{32'h0040_0ABC, 8'd5, 1'b1, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{32'h0080_0010, 8'd5, 1'b1, 32'h0011_1010, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[5] = '{32'h0080_0010, 8'd5, 1'b0, 32'h0011_1010, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{32'h0080_1FFF, 8'd5, 1'b0, 32'h0022_2FFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[7] = '{32'h0080_1004, 8'd5, 1'b1, 32'h0022_2004, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state and first miss
      do_reset();
      chk("rst_random", random_o, 32'd15);
      chk("rst_outs", {resp_valid, probe_valid, resp_paddr, probe_result}, 66'h0);
      do_lookup(32'h0040_0000, 8'd0, 1'b0);
      chk("first_miss", {resp_miss, resp_paddr}, {1'b1, 32'h0});

      // Indexed writes, then the lookup table
      do_write(4'd3, 1'b0, 32'h0040_0005, 32'h0048_D15E, 32'h0002_AF18);
      do_write(4'd4, 1'b0, 32'h0080_0005, 32'h0000_445A, 32'h0000_8896);
      for (int i = 0; i < 8; i++) begin
         do_lookup(vt[i].va, vt[i].asid, vt[i].store);
         chk($sformatf("vec%0d_paddr", i), resp_paddr, vt[i].pa);
         chk($sformatf("vec%0d_flags", i),
             {resp_miss, resp_invalid, resp_modified, resp_uncached},
             {vt[i].miss, vt[i].inv, vt[i].modf, vt[i].unc});
      end

      // Global entry in two slots: lowest index wins
      do_write(4'd2, 1'b0, 32'h1234_6009, 32'h0001_555F, 32'h0001_999F);
      do_write(4'd7, 1'b0, 32'h1234_6009, 32'h0001_DDDF, 32'h0001_DDDF);
      do_probe(32'h1234_6033);
      chk("probe_g", probe_result, 32'd2);
      do_probe(32'h1234_8000);
      chk("probe_none", probe_result, 32'h8000_0000);
      do_lookup(32'h1234_6ABC, 8'h77, 1'b0);
      chk("g_lookup", resp_paddr, 32'h0055_5ABC);

      // Probe in the same cycle as a write sees the old contents
      tlbp_en = 1'b1;
      do_write(4'd0, 1'b0, 32'h0040_0005, 32'h0048_D15E, 32'h0002_AF18);
      tlbp_en = 1'b0;
      chk("probe_prewrite", probe_result, 32'd3);
      do_probe(32'h0040_0005);
      chk("probe_postwrite", probe_result, 32'd0);

      // Random sequence with Wired = 4, then TLBWR at the sampled index
      wired_i = 4'd4;
      do_reset();
      chk("rand_start", random_o, 32'd15);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("rand_seq", random_o, (k < 12) ? 15 - k : 15);
      end
      do_write(4'd0, 1'b1, 32'h00C0_0001, 32'h0000_0006, 32'h0000_0006);
      do_probe(32'h00C0_0001);
      chk("tlbwr_idx", probe_result, 32'd15);

      // Write held high stalls lookups
      req_valid = 1'b1; req_vaddr = 32'h00C0_0123; req_asid = 8'd1;
      tlbw_en = 1'b1; tlbw_index = 4'd9; entryhi_i = 32'h00E0_0001;
      entrylo0_i = 32'h0000_0046; entrylo1_i = 32'h0000_0046;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("ready_hold", req_ready, 1'b0);
         tick();
      end
      idle();

      // Randomized traffic against the model
      wired_i = 4'd0;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] lo0, lo1;
         logic [18:0] vpn;
         vpn = 19'($urandom_range(1, 6));
         req_valid = ($urandom_range(0, 9) < 7);
         req_vaddr = {vpn, 1'($urandom), 12'($urandom)};
         req_asid  = 8'($urandom_range(1, 3));
         req_store = 1'($urandom);
         tlbw_en   = ($urandom_range(0, 3) == 0);
         tlbw_random = 1'($urandom);
         tlbw_index  = 4'($urandom);
         lo0 = $urandom; lo1 = $urandom;
         if ($urandom_range(0, 2) == 0) lo0[5:3] = 3'b010;
         if ($urandom_range(0, 2) == 0) lo1[5:3] = 3'b010;
         entryhi_i  = {19'($urandom_range(1, 6)), 5'h0, 8'($urandom_range(1, 3))};
         entrylo0_i = lo0; entrylo1_i = lo1;
         tlbp_en = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 19) == 0) wired_i = 4'($urandom);
         tick();
      end
      idle();

      // Statistics and reset during a pending lookup
      wired_i = 4'd0;
      do_reset();
      do_write(4'd1, 1'b0, 32'h0040_0005, 32'h0048_D15E, 32'h0002_AF18);
      for (int k = 0; k < 3; k++) do_lookup(32'h0040_0ABC, 8'd5, 1'b0);
      for (int k = 0; k < 2; k++) do_lookup(32'h0040_0ABC, 8'd7, 1'b0);
      chk("stats_hit", hit_count, STATS ? 32'd3 : 32'd0);
      chk("stats_miss", miss_count, STATS ? 32'd2 : 32'd0);

      req_valid = 1'b1; req_vaddr = 32'h0040_0ABC; req_asid = 8'd5;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_drop_pre", resp_valid, 1'b0);
      req_valid = 1'b0;
      rst = 1'b0;
      model_clear();
      chk("rst_cnt", {hit_count, miss_count}, 64'h0);
      tick();

      req_valid = 1'b1; req_vaddr = 32'h0040_0ABC; req_asid = 8'd5;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_drop_post", resp_valid, 1'b0);
      req_valid = 1'b0;
      rst = 1'b0;
      model_clear();
      tick();
      chk("rst_cnt2", {hit_count, miss_count}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
